// File: rtl/ir_pkg.sv
// Shared IR link definitions: transmitter FSM states, default pulse timing
// in tick-clock cycles, and the receiver decode thresholds.
package ir_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        START_MARK  = 3'd1,
        START_SPACE = 3'd2,
        BIT_MARK    = 3'd3,
        BIT_SPACE   = 3'd4
    } ir_tx_state_t;

    localparam int IR_T_START = 9;
    localparam int IR_T_ONE   = 4;
    localparam int IR_T_ZERO  = 1;
    localparam int IR_T_GAP   = 2;

    // Receiver classifies a mark as bit 1 at >= IR_DEC_ONE_MIN, start at >= IR_DEC_START_MIN.
    localparam int IR_DEC_ONE_MIN   = 3;
    localparam int IR_DEC_START_MIN = 7;

    function automatic int ir_max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ir_pulse_timer.sv
// Loadable down-counter that times marks and spaces; holds at zero until
// reloaded, so zero_o marks the last cycle of the current interval.
module ir_pulse_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] value_o,
    output logic         zero_o
);

    logic [W-1:0] value_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value_q <= '0;
        end else if (load_i) begin
            value_q <= load_val_i;
        end else if (value_q != '0) begin
            value_q <= value_q - W'(1);
        end
    end

    assign value_o = value_q;
    assign zero_o  = (value_q == '0);

endmodule

// File: rtl/ir_tx.sv
// Pulse-width-coded IR transmitter: start mark, then one mark per bit (MSB
// first) whose length encodes the bit, each mark followed by a T_GAP space.
module ir_tx
    import ir_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int T_START = IR_T_START,
    parameter int T_ONE   = IR_T_ONE,
    parameter int T_ZERO  = IR_T_ZERO,
    parameter int T_GAP   = IR_T_GAP,
    localparam int CNT_W  = $clog2(ir_max3(T_START, T_ONE, T_GAP)),
    localparam int IDX_W  = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] data,
    input  logic              valid,
    output logic              ready,
    output logic              irout,
    output logic              busy,
    output logic              done,
    output ir_tx_state_t      dbg_state,
    output logic [CNT_W-1:0]  dbg_count
);

    if (DATA_W < 1) begin : g_bad_data_w
        $error("ir_tx: DATA_W must be >= 1");
    end
    if (T_START < 7) begin : g_bad_t_start
        $error("ir_tx: T_START must be >= 7");
    end
    if (T_ONE < 3 || T_ONE > 6) begin : g_bad_t_one
        $error("ir_tx: T_ONE must be in 3..6");
    end
    if (T_ZERO < 1 || T_ZERO > 2) begin : g_bad_t_zero
        $error("ir_tx: T_ZERO must be in 1..2");
    end
    if (T_GAP < 1) begin : g_bad_t_gap
        $error("ir_tx: T_GAP must be >= 1");
    end

    ir_tx_state_t      state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              irout_q, done_q, done_d;
    logic              tmr_load;
    logic [CNT_W-1:0]  tmr_load_val, tmr_value;
    logic              tmr_zero;

    function automatic logic [CNT_W-1:0] mark_len(input logic bit_val);
        return bit_val ? CNT_W'(T_ONE - 1) : CNT_W'(T_ZERO - 1);
    endfunction

    ir_pulse_timer #(.W(CNT_W)) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .value_o    (tmr_value),
        .zero_o     (tmr_zero)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            irout_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            // Envelope follows the registered state one cycle later, so it can never glitch.
            irout_q <= (state_q == START_MARK) || (state_q == BIT_MARK);
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        idx_d        = idx_q;
        done_d       = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        case (state_q)
            IDLE: begin
                if (valid) begin
                    shift_d      = data;
                    idx_d        = IDX_W'(DATA_W);
                    tmr_load     = 1'b1;
                    tmr_load_val = CNT_W'(T_START - 1);
                    state_d      = START_MARK;
                end
            end
            START_MARK: begin
                if (tmr_zero) begin
                    tmr_load     = 1'b1;
                    tmr_load_val = CNT_W'(T_GAP - 1);
                    state_d      = START_SPACE;
                end
            end
            START_SPACE: begin
                if (tmr_zero) begin
                    tmr_load     = 1'b1;
                    tmr_load_val = mark_len(shift_q[DATA_W-1]);
                    state_d      = BIT_MARK;
                end
            end
            BIT_MARK: begin
                if (tmr_zero) begin
                    tmr_load     = 1'b1;
                    tmr_load_val = CNT_W'(T_GAP - 1);
                    state_d      = BIT_SPACE;
                end
            end
            BIT_SPACE: begin
                if (tmr_zero) begin
                    shift_d = shift_q << 1;
                    idx_d   = idx_q - IDX_W'(1);
                    if (idx_q == IDX_W'(1)) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        tmr_load     = 1'b1;
                        tmr_load_val = mark_len(shift_d[DATA_W-1]);
                        state_d      = BIT_MARK;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ready     = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign irout     = irout_q;
    assign done      = done_q;
    assign dbg_state = state_q;
    assign dbg_count = tmr_value;

endmodule
